// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - bomb countdown timer with M:SS ASCII display; optional strike penalty via COUNTDOWN_STRIKE_PENALTY_EN
module countdown_timer #(
    parameter int TICK_DIV        = 65000000,
    parameter int START_SECONDS   = 300,
    parameter int PENALTY_SECONDS = 30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        begin_timer,
    input  logic        enable,
    input  logic        strike,
    output logic [9:0]  seconds_left,
    output logic [23:0] ascii_timer,
    output logic        running,
    output logic        expired
);

    localparam int             PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  LP_LAST  = PW'(TICK_DIV - 1);
    localparam logic [9:0]     LP_START = 10'(START_SECONDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_EXPIRED
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [PW-1:0] r_prescale;
    logic [PW-1:0] w_prescale_next;
    logic [9:0]    r_seconds;
    logic [9:0]    w_seconds_next;
    logic [23:0]   r_ascii;
    logic          w_tick;
    logic [10:0]   w_dec;

    // Binary seconds to three ASCII characters {minute, tens, ones}.
    function automatic logic [23:0] f_to_ascii(input logic [9:0] s);
        logic [9:0] m;
        logic [9:0] r;
        logic [9:0] t;
        logic [9:0] o;
        m = s / 10'd60;
        r = s % 10'd60;
        t = r / 10'd10;
        o = r % 10'd10;
        return {8'(10'h30 + m), 8'(10'h30 + t), 8'(10'h30 + o)};
    endfunction

    assign w_tick = (r_state == S_COUNT) && enable && (r_prescale == LP_LAST);

`ifndef COUNTDOWN_STRIKE_PENALTY_EN
    logic w_unused_strike;
    assign w_unused_strike = strike & (PENALTY_SECONDS != 0);
`endif

    // Next-state logic: restart wins over everything, then prescaler and decrement.
    always_comb begin
        w_state_next    = r_state;
        w_prescale_next = r_prescale;
        w_seconds_next  = r_seconds;
        w_dec           = {10'd0, w_tick};
`ifdef COUNTDOWN_STRIKE_PENALTY_EN
        if (strike) begin
            w_dec = w_dec + 11'(PENALTY_SECONDS);
        end
`endif
        if (begin_timer) begin
            w_state_next    = S_COUNT;
            w_prescale_next = '0;
            w_seconds_next  = LP_START;
        end else if (r_state == S_COUNT) begin
            if (enable) begin
                w_prescale_next = w_tick ? '0 : r_prescale + 1'b1;
            end
            // Saturate at zero; reaching zero ends the countdown in the same update.
            if (w_dec >= {1'b0, r_seconds}) begin
                w_seconds_next = '0;
                w_state_next   = S_EXPIRED;
            end else begin
                w_seconds_next = r_seconds - w_dec[9:0];
            end
        end
    end

    // State, prescaler, seconds and registered display conversion.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_prescale <= '0;
            r_seconds  <= LP_START;
            r_ascii    <= f_to_ascii(LP_START);
        end else begin
            r_state    <= w_state_next;
            r_prescale <= w_prescale_next;
            r_seconds  <= w_seconds_next;
            r_ascii    <= f_to_ascii(r_seconds);
        end
    end

    assign seconds_left = r_seconds;
    assign ascii_timer  = r_ascii;
    assign running      = (r_state == S_COUNT);
    assign expired      = (r_state == S_EXPIRED);

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Bomb countdown stage feeding gameFSM.
- Consumes begin_timer (start pulse) and enable (play level) from gameFSM.
- Produces ascii_timer (3 ASCII chars, M:SS) for the PLAYING_GAME display string.
- Produces expired, which drives gameFSM game_lost when the clock reaches 0:00.

Parameters:
- TICK_DIV, 65000000, clock cycles per one-second tick (65 MHz game clock); benches override with small values.
- START_SECONDS, 300, value loaded on begin_timer; legal range 1..599 (display limit 9:59).
- PENALTY_SECONDS, 30, seconds removed per strike; used only with the optional feature.

Ports:
- clock  input  1  game clock, 65 MHz
- reset  input  1  synchronous, active-high
- begin_timer  input  1  one-cycle pulse from gameFSM; loads START_SECONDS and starts counting
- enable  input  1  level from gameFSM; counting advances only while high
- strike  input  1  one-cycle pulse from bomb logic on a wrong action; used only with the optional feature
- seconds_left  output  10  binary seconds remaining (registered)
- ascii_timer  output  24  {minute digit, seconds tens, seconds ones}; each char = 8'h30 + digit
- running  output  1  high while counting is armed
- expired  output  1  level; high from reaching 0 until next begin_timer or reset

Behaviour:
- Reset (synchronous, highest priority):
  - seconds_left = START_SECONDS; prescaler = 0; running = 0; expired = 0.
  - ascii_timer shows START_SECONDS, e.g. "5","0","0" for the default.
- Prescaler: counts 0..TICK_DIV-1 only while running && enable.
  - tick = 1 in the cycle the prescaler equals TICK_DIV-1; the prescaler wraps to 0 in that cycle.
  - enable low freezes the prescaler and seconds_left. No reset of the partial second.
- Tick with running: seconds_left <= seconds_left - 1, visible the cycle after the tick cycle.
- Reaching 0 (seconds_left becomes 0 by any path):
  - In that same update: running <= 0; expired <= 1.
  - No further decrement; no wrap below 0.
- begin_timer:
  - seconds_left <= START_SECONDS; prescaler <= 0; running <= 1; expired <= 0.
  - Accepted in any state, including mid-count and while expired (restart).
  - Takes priority over a coincident tick or strike.
- Not running (before first begin_timer or after expiry): tick and strike are ignored.
- Display conversion is registered, 1 cycle after seconds_left:
  - minute = seconds_left / 60.
  - rem = seconds_left % 60.
  - tens = rem / 10.
  - ones = rem % 10.
  - Total latency from tick to ascii_timer update = 2 cycles.
- Boundary: START_SECONDS=1 expires on the first tick.
- State machine, 3 states:
  - IDLE (after reset): begin_timer -> COUNT.
  - COUNT (running=1): reaching 0 -> EXPIRED; begin_timer -> COUNT (reload).
  - EXPIRED (expired=1): begin_timer -> COUNT.
  - Reset returns to IDLE from any state.

Optional Feature:
- Macro: COUNTDOWN_STRIKE_PENALTY_EN.
- Defined:
  - A strike pulse while running subtracts PENALTY_SECONDS, saturating at 0.
  - Strike coincident with a tick subtracts PENALTY_SECONDS+1, also saturating.
  - Saturating to 0 sets expired / clears running in the same update.
  - The prescaler is unaffected by a strike.
- Undefined: the strike port exists but is ignored entirely.

Test Plan:
- TICK_DIV=4, START_SECONDS=300: reset, then begin_timer pulse. After 4 enabled cycles, seconds_left=299; 2 cycles after the tick, ascii_timer = "4","5","9".
- TICK_DIV=4, START_SECONDS=2: begin_timer, hold enable. After 8 cycles, seconds_left=0, expired=1, running=0; further cycles hold 0:00 with expired=1.
- Pause: enable low for 20 cycles mid-second. seconds_left and prescaler hold; after enable returns, the tick arrives after only the remaining prescaler count.
- Restart: while expired=1, pulse begin_timer coincident with a strike. Result: seconds_left=START_SECONDS, expired=0, running=1.
- COUNTDOWN_STRIKE_PENALTY_EN defined, seconds_left=45, PENALTY_SECONDS=30:
  - First strike -> 15, ascii_timer = "0","1","5".
  - Second strike -> 0, expired=1.
  - Without the macro, the same strikes leave seconds_left unchanged.
- Reset asserted mid-count at seconds_left=123: next cycle seconds_left=300, running=0, expired=0; ticks are ignored until begin_timer.
